// File: rtl/regsw_pkg.sv
// Shared op codes and FSM state encodings for the register transfer switch.
package regsw_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_READ  = 2'b00;
   localparam op_t OP_WRITE = 2'b01;
   localparam op_t OP_COPY  = 2'b10;
   localparam op_t OP_CLEAR = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RESP = 2'd1;
   localparam logic [1:0] ST_COPY = 2'd2;

endpackage

// File: rtl/reg_xfer_switch_if.sv
// Request/response bundle between the control FSM (master) and the switch (slave).
interface reg_xfer_switch_if
   import regsw_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 8
);
   localparam int unsigned SELW = $clog2(NREGS);

   logic                   req_valid;
   logic                   req_ready;
   op_t                    req_op;
   logic [SELW-1:0]        req_sel;
   logic [SELW-1:0]        req_dst;
   logic [WIDTH-1:0]       wr_data;
   logic                   rd_valid;
   logic                   rd_ready;
   logic [WIDTH-1:0]       rd_data;
   logic                   busy;
   logic [NREGS*WIDTH-1:0] reg_flat;

   modport master (
      output req_valid, req_op, req_sel, req_dst, wr_data, rd_ready,
      input  req_ready, rd_valid, rd_data, busy, reg_flat
   );

   modport slave (
      input  req_valid, req_op, req_sel, req_dst, wr_data, rd_ready,
      output req_ready, rd_valid, rd_data, busy, reg_flat
   );

endinterface

// File: rtl/regsw_bank.sv
// Register storage: one write port, bulk clear, async read mux, flat view.
module regsw_bank #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      NREGS     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned     SELW      = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   we,
   input  logic [SELW-1:0]        waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic [SELW-1:0]        raddr,
   output logic [WIDTH-1:0]       rdata,
   output logic [NREGS*WIDTH-1:0] reg_flat
);

   logic [WIDTH-1:0] mem [NREGS];

   // Out-of-range write addresses match no entry and are dropped.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NREGS); i++) begin
         if (rst || clr) begin
            mem[i] <= RESET_VAL;
         end else if (we && waddr == SELW'(i)) begin
            mem[i] <= wdata;
         end
      end
   end

   // Out-of-range read addresses fall through to zero.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (raddr == SELW'(i)) rdata = mem[i];
      end
   end

   always_comb begin
      reg_flat = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         reg_flat[i*WIDTH +: WIDTH] = mem[i];
      end
   end

endmodule

// File: rtl/reg_xfer_switch.sv
// Handshaked transfer engine (read/write/copy/clear) in front of a register bank.
module reg_xfer_switch
   import regsw_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      NREGS     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned     SELW      = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   reg_xfer_switch_if.slave bus
);

   logic [1:0]       state, state_nxt;
   logic [WIDTH-1:0] tmp_q, tmp_nxt;
   logic [SELW-1:0]  dst_q, dst_nxt;
   logic             rd_valid_q, rd_valid_nxt;
   logic [WIDTH-1:0] rd_data_q, rd_data_nxt;

   logic             we, clr;
   logic [SELW-1:0]  waddr, raddr;
   logic [WIDTH-1:0] wdata, rdata;

   regsw_bank #(
      .WIDTH     (WIDTH),
      .NREGS     (NREGS),
      .RESET_VAL (RESET_VAL)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr    (raddr),
      .rdata    (rdata),
      .reg_flat (bus.reg_flat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         tmp_q      <= '0;
         dst_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state      <= state_nxt;
         tmp_q      <= tmp_nxt;
         dst_q      <= dst_nxt;
         rd_valid_q <= rd_valid_nxt;
         rd_data_q  <= rd_data_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tmp_nxt      = tmp_q;
      dst_nxt      = dst_q;
      rd_valid_nxt = rd_valid_q;
      rd_data_nxt  = rd_data_q;
      we           = 1'b0;
      clr          = 1'b0;
      waddr        = bus.req_sel;
      wdata        = bus.wr_data;
      raddr        = bus.req_sel;

      case (state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               case (bus.req_op)
                  OP_READ: begin
                     rd_data_nxt  = rdata;
                     rd_valid_nxt = 1'b1;
                     state_nxt    = ST_RESP;
                  end
                  OP_WRITE: we = 1'b1;
                  OP_COPY: begin
                     tmp_nxt   = rdata;
                     dst_nxt   = bus.req_dst;
                     state_nxt = ST_COPY;
                  end
                  default: clr = 1'b1;
               endcase
            end
         end
         ST_RESP: begin
            if (bus.rd_ready) begin
               rd_valid_nxt = 1'b0;
               state_nxt    = ST_IDLE;
            end
         end
         ST_COPY: begin
            // Second half of a copy commits the captured value to the destination.
            we        = 1'b1;
            waddr     = dst_q;
            wdata     = tmp_q;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.req_ready = !rst && (state == ST_IDLE);
   assign bus.busy      = !rst && (state != ST_IDLE);
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_reg_xfer_switch.sv
// Random + directed check of reg_xfer_switch (NREGS=8 and NREGS=5) against an array model.
module tb_reg_xfer_switch;
   import regsw_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_xfer_switch_if #(.WIDTH(8), .NREGS(8)) b8 ();
   reg_xfer_switch_if #(.WIDTH(8), .NREGS(5)) b5 ();

   reg_xfer_switch #(.WIDTH(8), .NREGS(8), .RESET_VAL(8'h00)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
   reg_xfer_switch #(.WIDTH(8), .NREGS(5), .RESET_VAL(8'h00)) dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

   // Both instances see identical stimulus; only their models differ.
   assign b5.req_valid = b8.req_valid;
   assign b5.req_op    = b8.req_op;
   assign b5.req_sel   = b8.req_sel;
   assign b5.req_dst   = b8.req_dst;
   assign b5.wr_data   = b8.wr_data;
   assign b5.rd_ready  = b8.rd_ready;

   logic [7:0] m8 [8];
   logic [7:0] m5 [5];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] flat8();
      logic [63:0] f;
      for (int i = 0; i < 8; i++) f[i*8 +: 8] = m8[i];
      return f;
   endfunction

   function automatic logic [39:0] flat5();
      logic [39:0] f;
      for (int i = 0; i < 5; i++) f[i*8 +: 8] = m5[i];
      return f;
   endfunction

   function automatic logic [7:0] rd5(input int s);
      return (s < 5) ? m5[s] : 8'h00;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m8[i] = 8'h00;
      for (int i = 0; i < 5; i++) m5[i] = 8'h00;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, "_flat8"}, b8.reg_flat, flat8());
      chk({tag, "_flat5"}, 64'(b5.reg_flat), 64'(flat5()));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy"}, {b8.req_ready, b5.req_ready}, 2'b11);
      chk({tag, "_busy"}, {b8.busy, b5.busy}, 2'b00);
      chk({tag, "_rdv"}, {b8.rd_valid, b5.rd_valid}, 2'b00);
   endtask

   task automatic issue(input op_t op, input int sel, input int dst, input logic [7:0] d);
      b8.req_valid = 1'b1;
      b8.req_op    = op;
      b8.req_sel   = 3'(sel);
      b8.req_dst   = 3'(dst);
      b8.wr_data   = d;
      chk("accept_rdy", {b8.req_ready, b5.req_ready}, 2'b11);
      tick();
      b8.req_valid = 1'b0;
      b8.req_op    = 2'($urandom);
      b8.req_sel   = 3'($urandom);
      b8.wr_data   = 8'($urandom);
   endtask

   task automatic do_write(input int sel, input logic [7:0] d);
      issue(OP_WRITE, sel, 0, d);
      m8[sel] = d;
      if (sel < 5) m5[sel] = d;
      chk_regs("wr");
   endtask

   task automatic do_read(input int sel, input int hold);
      logic [7:0] e8, e5;
      e8 = m8[sel];
      e5 = rd5(sel);
      b8.rd_ready = 1'b0;
      issue(OP_READ, sel, 0, 8'h00);
      for (int k = 0; k <= hold; k++) begin
         chk("rd_valid", {b8.rd_valid, b5.rd_valid}, 2'b11);
         chk("rd_data8", 64'(b8.rd_data), 64'(e8));
         chk("rd_data5", 64'(b5.rd_data), 64'(e5));
         chk("rd_rdy", {b8.req_ready, b5.req_ready}, 2'b00);
         if (k < hold) tick();
      end
      b8.rd_ready = 1'b1;
      tick();
      b8.rd_ready = 1'($urandom);
      chk_idle("rd_done");
   endtask

   task automatic do_copy(input int sel, input int dst, input bit abort);
      logic [7:0] t8, t5;
      t8 = m8[sel];
      t5 = rd5(sel);
      issue(OP_COPY, sel, dst, 8'h00);
      chk("cp_busy", {b8.busy, b5.busy}, 2'b11);
      chk("cp_rdy", {b8.req_ready, b5.req_ready}, 2'b00);
      if (abort) begin
         rst = 1'b1;
         #1;
         chk("rst_rdy", {b8.req_ready, b5.req_ready}, 2'b00);
         chk("rst_busy", {b8.busy, b5.busy}, 2'b00);
         tick();
         model_clear();
         chk_regs("abort");
         chk("abort_rdv", {b8.rd_valid, b5.rd_valid}, 2'b00);
         chk("abort_rdd", {b8.rd_data, b5.rd_data}, 16'h0000);
         rst = 1'b0;
         #1;
         chk_idle("abort_exit");
      end else begin
         tick();
         m8[dst] = t8;
         if (dst < 5) m5[dst] = t5;
         chk_idle("cp_done");
         chk_regs("cp");
      end
   endtask

   task automatic do_clear();
      issue(OP_CLEAR, 0, 0, 8'h00);
      model_clear();
      chk_regs("clr");
      chk_idle("clr");
   endtask

   initial begin
      b8.req_valid = 1'b0;
      b8.req_op    = OP_READ;
      b8.req_sel   = '0;
      b8.req_dst   = '0;
      b8.wr_data   = '0;
      b8.rd_ready  = 1'b0;
      for (int i = 0; i < 8; i++) m8[i] = 8'hXX;
      for (int i = 0; i < 5; i++) m5[i] = 8'hXX;

      tick();
      tick();
      chk("in_rst_rdy", {b8.req_ready, b5.req_ready}, 2'b00);
      chk("in_rst_busy", {b8.busy, b5.busy}, 2'b00);
      model_clear();
      chk_regs("rst");
      chk("rst_rdd", {b8.rd_data, b5.rd_data}, 16'h0000);
      rst = 1'b0;
      #1;
      chk_idle("post_rst");

      do_write(3, 8'hA5);
      do_write(7, 8'h3C);
      chk("reg3", 64'(b8.reg_flat[31:24]), 64'h A5);
      chk("reg7", 64'(b8.reg_flat[63:56]), 64'h 3C);
      do_read(3, 3);
      do_copy(3, 0, 1'b0);
      do_copy(3, 3, 1'b0);
      do_copy(7, 1, 1'b1);

      do_write(6, 8'h77);
      do_write(2, 8'h55);
      do_read(6, 1);
      do_copy(6, 1, 1'b0);
      do_copy(2, 6, 1'b0);
      do_clear();

      for (int n = 0; n < 300; n++) begin
         int r, s, d;
         r = $urandom_range(0, 19);
         s = $urandom_range(0, 7);
         d = $urandom_range(0, 7);
         if (r < 8)       do_write(s, 8'($urandom));
         else if (r < 13) do_read(s, $urandom_range(0, 3));
         else if (r < 17) do_copy(s, d, 1'b0);
         else if (r < 18) do_copy(s, d, 1'b1);
         else             do_clear();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
